// File: rtl/buck_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// buck_pwm_ctrl
//   Fixed-frequency PWM controller for a buck converter gate drive. It has a
//   soft-start ramp, a duty clamp, a fault latch, and a configuration handshake
//   that applies a new period/duty only on a period boundary.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   en              : converter enable (level)
//   period_in       : requested period in clocks (clamped to >= 2 on apply)
//   duty_in         : requested on-time in clocks (clamped to DMAX_PCT % on apply)
//   cfg_valid       : configuration offer
//   cfg_ready       : configuration accept (low while a configuration is pending)
//   fault           : overcurrent flag, already synchronous to clk
//   fault_clr       : fault acknowledge pulse
//   ctrl            : registered gate drive, 1 = switch closed
//   cyc_start       : high for the clock in which the period counter is 0
//   state           : FSM state, IDLE=0 SOFTSTART=1 RUN=2 FAULT=3
//   duty_act        : on-time currently in effect
//
// Handshake: a transfer happens on any rising edge where cfg_valid and cfg_ready
// are both 1. cfg_valid may be raised regardless of cfg_ready. cfg_ready is 1
// exactly when the single pending slot is empty. The slot is drained on a
// period wrap, or on any edge while IDLE. The slot survives IDLE and FAULT.
// -----------------------------------------------------------------------------
module buck_pwm_ctrl #(
   parameter int CNT_W      = 16,
   parameter int PERIOD_RST = 1000,
   parameter int DUTY_RST   = 500,
   parameter int DMAX_PCT   = 90,
   parameter int SS_STEP    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] period_in,
   input  logic [CNT_W-1:0] duty_in,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             fault,
   input  logic             fault_clr,
   output logic             ctrl,
   output logic             cyc_start,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] duty_act
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SOFT  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // Reset-time operating point, clamped with the same rules as a runtime apply.
   localparam int PER_RST_CL = (PERIOD_RST < 2) ? 2 : PERIOD_RST;
   localparam int DMAX_RST   = (PER_RST_CL * DMAX_PCT) / 100;
   localparam int TGT_RST    = (DUTY_RST < DMAX_RST) ? DUTY_RST : DMAX_RST;

   localparam logic [CNT_W-1:0]   PER_RST_V = CNT_W'(PER_RST_CL);
   localparam logic [CNT_W-1:0]   TGT_RST_V = CNT_W'(TGT_RST);
   localparam logic [2*CNT_W-1:0] DMAX_W    = (2*CNT_W)'(DMAX_PCT);
   localparam logic [2*CNT_W-1:0] HUND_W    = (2*CNT_W)'(100);
   localparam logic [CNT_W:0]     SS_W      = (CNT_W+1)'(SS_STEP);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ctrl_q, ctrl_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [CNT_W-1:0] tgt_q, tgt_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] pend_per_q, pend_per_d;
   logic [CNT_W-1:0] pend_duty_q, pend_duty_d;

   logic             running;
   logic             wrap;
   logic             apply_en;
   logic [CNT_W-1:0] clamp_per;
   logic [CNT_W-1:0] clamp_dmax;
   logic [CNT_W-1:0] clamp_tgt;
   logic [CNT_W:0]   ss_sum;

   always_comb begin
      running = (state_q == ST_SOFT) || (state_q == ST_RUN);
      wrap    = running && (cnt_q == (per_q - CNT_W'(1)));

      // Clamp the pending request at apply time. The product uses a
      // double-width intermediate so that per*DMAX_PCT cannot overflow.
      clamp_per  = (pend_per_q < CNT_W'(2)) ? CNT_W'(2) : pend_per_q;
      clamp_dmax = CNT_W'(({{CNT_W{1'b0}}, clamp_per} * DMAX_W) / HUND_W);
      clamp_tgt  = (pend_duty_q < clamp_dmax) ? pend_duty_q : clamp_dmax;

      // Fault blocks an apply. Dropping en mid-period also blocks it: the
      // slot is then drained on the next edge spent in IDLE.
      apply_en = pend_q && !fault &&
                 ((state_q == ST_IDLE) || (running && en && wrap));

      per_d       = apply_en ? clamp_per : per_q;
      tgt_d       = apply_en ? clamp_tgt : tgt_q;
      pend_d      = apply_en ? 1'b0 : pend_q;
      pend_per_d  = pend_per_q;
      pend_duty_d = pend_duty_q;

      state_d = state_q;
      cnt_d   = '0;
      duty_d  = '0;
      ss_sum  = {1'b0, duty_q} + SS_W;

      if (fault) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) state_d = ST_SOFT;
            end
            ST_FAULT: begin
               if (fault_clr) state_d = ST_IDLE;
            end
            default: begin
               if (!en) begin
                  state_d = ST_IDLE;
               end else if (wrap) begin
                  if (state_q == ST_SOFT) begin
                     // Ramp toward the newly applied target. A target lowered
                     // below the ramp lands on it at once and ends the ramp.
                     duty_d = (ss_sum < {1'b0, tgt_d}) ? ss_sum[CNT_W-1:0] : tgt_d;
                     if (duty_d == tgt_d) state_d = ST_RUN;
                  end else begin
                     duty_d = tgt_d;
                  end
               end else begin
                  cnt_d  = cnt_q + CNT_W'(1);
                  duty_d = duty_q;
               end
            end
         endcase
      end

      // ctrl is decided from the values being loaded on this edge, so a new
      // period starts with its own on-time.
      ctrl_d = ((state_d == ST_SOFT) || (state_d == ST_RUN)) && (cnt_d < duty_d);

      // A capture needs an empty slot and an apply needs a full one, so the
      // two never happen on the same edge.
      if (cfg_valid && !pend_q) begin
         pend_d      = 1'b1;
         pend_per_d  = period_in;
         pend_duty_d = duty_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ctrl_q      <= 1'b0;
         duty_q      <= '0;
         per_q       <= PER_RST_V;
         tgt_q       <= TGT_RST_V;
         pend_q      <= 1'b0;
         pend_per_q  <= '0;
         pend_duty_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ctrl_q      <= ctrl_d;
         duty_q      <= duty_d;
         per_q       <= per_d;
         tgt_q       <= tgt_d;
         pend_q      <= pend_d;
         pend_per_q  <= pend_per_d;
         pend_duty_q <= pend_duty_d;
      end
   end

   assign ctrl      = ctrl_q;
   assign cyc_start = running && (cnt_q == '0);
   assign state     = state_q;
   assign duty_act  = duty_q;
   assign cfg_ready = !pend_q;

endmodule
